// File: rtl/led_s2p_rx.sv
// Receiving end of the LED shift-register link: oversamples sclk/sdin/sclrn/en in
// the clk domain, rebuilds the shifted word and presents it with a valid strobe on each latch.
module led_s2p_rx #(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned DATA_COUNT_BITS = 5,
    parameter int unsigned DIR             = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       sdin,
    input  logic                       sclrn,
    input  logic                       en,
    output logic [DATA_BITS-1:0]       PData,
    output logic                       valid,
    output logic                       frame_err,
    output logic                       busy,
    output logic [DATA_COUNT_BITS-1:0] bit_cnt
);

    localparam logic [DATA_COUNT_BITS-1:0] CNT_FULL = DATA_COUNT_BITS'(DATA_BITS);
    localparam logic [DATA_COUNT_BITS-1:0] CNT_SAT  = DATA_COUNT_BITS'(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t               state;
    logic [1:0]           sclk_sy, sdin_sy, sclrn_sy, en_sy;
    logic                 sclk_d, en_d;
    logic [DATA_BITS-1:0] sr, sr_shift;
    logic                 sclk_s, sdin_s, sclrn_s, en_s;
    logic                 sclk_rise, en_rise;

    assign sclk_s    = sclk_sy[1];
    assign sdin_s    = sdin_sy[1];
    assign sclrn_s   = sclrn_sy[1];
    assign en_s      = en_sy[1];
    // Shift clock edges are ignored while the latch strobe is held high
    assign sclk_rise = sclk_s & ~sclk_d & ~en_s;
    assign en_rise   = en_s & ~en_d;

    // Next shift-register value for the configured bit order
    always_comb begin
        sr_shift = sr;
        if (DIR == 0) begin
            sr_shift = {sr[DATA_BITS-2:0], sdin_s};
        end else begin
            sr_shift = {sdin_s, sr[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy   <= '0;
            sdin_sy   <= '0;
            sclrn_sy  <= '0;
            en_sy     <= '0;
            sclk_d    <= 1'b0;
            en_d      <= 1'b0;
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            PData     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_sy  <= {sclk_sy[0], sclk};
            sdin_sy  <= {sdin_sy[0], sdin};
            sclrn_sy <= {sclrn_sy[0], sclrn};
            en_sy    <= {en_sy[0], en};
            sclk_d   <= sclk_s;
            en_d     <= en_s;
            valid    <= 1'b0;

            if (!sclrn_s) begin
                sr      <= '0;
                bit_cnt <= '0;
                state   <= IDLE;
                busy    <= 1'b0;
            end else if (en_rise && state != LATCH) begin
                state <= LATCH;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sclk_rise) begin
                            sr      <= sr_shift;
                            bit_cnt <= DATA_COUNT_BITS'(1);
                            state   <= RECV;
                            busy    <= 1'b1;
                        end
                    end
                    RECV: begin
                        if (sclk_rise) begin
                            sr <= sr_shift;
                            if (bit_cnt != CNT_SAT) begin
                                bit_cnt <= bit_cnt + DATA_COUNT_BITS'(1);
                            end
                        end
                    end
                    LATCH: begin
                        PData     <= sr;
                        valid     <= 1'b1;
                        frame_err <= (bit_cnt != CNT_FULL);
                        sr        <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_s2p_rx.sv
// Bench for led_s2p_rx: MSB-first and LSB-first instances share one serial link;
// latched words are scoreboarded against table/hand-written expectations.
module tb_led_s2p_rx;

    logic        clk = 1'b0;
    logic        rst, sclk, sdin, sclrn, en;
    logic [15:0] pdata0, pdata1;
    logic        valid0, valid1, ferr0, ferr1, busy0, busy1;
    logic [4:0]  cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        int          n;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        err;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    always #5 clk = ~clk;

    led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .DIR(0)) u_msb (
        .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .sclrn(sclrn), .en(en),
        .PData(pdata0), .valid(valid0), .frame_err(ferr0), .busy(busy0), .bit_cnt(cnt0)
    );

    led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .DIR(1)) u_lsb (
        .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .sclrn(sclrn), .en(en),
        .PData(pdata1), .valid(valid1), .frame_err(ferr1), .busy(busy1), .bit_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every valid strobe must match the oldest pending latch
    always @(negedge clk) begin
        if (!rst && valid0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pdata_msb", 32'(pdata0), 32'(e.exp0));
                chk("pdata_lsb", 32'(pdata1), 32'(e.exp1));
                chk("frame_err_msb", 32'(ferr0), 32'(e.err));
                chk("frame_err_lsb", 32'(ferr1), 32'(e.err));
                chk("valid_lsb", 32'(valid1), 32'd1);
            end
        end
    end

    // Shift n bits, data[n-1] first, sclk period 20 clk
    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdin = d[i];
            repeat (5) @(posedge clk);
            sclk = 1'b1;
            repeat (10) @(posedge clk);
            sclk = 1'b0;
            repeat (5) @(posedge clk);
        end
        repeat (5) @(posedge clk);
    endtask

    // Raise en, check the strobe timing, optionally toggle sclk while en is held high
    task automatic pulse_en(input logic [15:0] e0, input logic [15:0] e1, input logic err,
                            input int toggles);
        exp_t e;
        e.exp0 = e0;
        e.exp1 = e1;
        e.err  = err;
        sb.push_back(e);
        @(posedge clk);
        #1 en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("valid_early", 32'(valid0), 32'd0);
        @(negedge clk);
        chk("valid_on_time", 32'(valid0), 32'd1);
        @(negedge clk);
        chk("valid_one_cycle", 32'(valid0), 32'd0);
        for (int t = 0; t < toggles; t++) begin
            sdin = 1'b1;
            sclk = 1'b1;
            repeat (8) @(posedge clk);
            sclk = 1'b0;
            repeat (8) @(posedge clk);
        end
        @(negedge clk);
        chk("bit_cnt_after_latch", 32'(cnt0), 32'd0);
        chk("busy_after_latch", 32'(busy0), 32'd0);
        en = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{data: 32'h0000A5C3, n: 16, exp0: 16'hA5C3, exp1: 16'hC3A5, err: 1'b0};
        vecs[1] = '{data: 32'h00008000, n: 16, exp0: 16'h8000, exp1: 16'h0001, err: 1'b0};
        vecs[2] = '{data: 32'h000000FF, n: 8,  exp0: 16'h00FF, exp1: 16'hFF00, err: 1'b1};
        vecs[3] = '{data: 32'h00001234, n: 16, exp0: 16'h1234, exp1: 16'h2C48, err: 1'b0};
        vecs[4] = '{data: 32'h00018001, n: 17, exp0: 16'h8001, exp1: 16'h8001, err: 1'b1};

        rst = 1'b1; sclk = 1'b0; sdin = 1'b0; sclrn = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pdata", 32'(pdata0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_frame_err", 32'(ferr0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_bit_cnt", 32'(cnt0), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            send_bits(vecs[v].data, vecs[v].n);
            @(negedge clk);
            chk("bit_cnt_pre_latch", 32'(cnt0), 32'(vecs[v].n > 17 ? 17 : vecs[v].n));
            chk("bit_cnt_pre_latch_lsb", 32'(cnt1), 32'(vecs[v].n > 17 ? 17 : vecs[v].n));
            chk("busy_pre_latch", 32'(busy0), 32'd1);
            pulse_en(vecs[v].exp0, vecs[v].exp1, vecs[v].err, 0);
        end

        // Clear mid-frame: partial bits dropped, latched outputs untouched
        send_bits(32'h3FF, 10);
        @(posedge clk);
        #1 sclrn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("clear_bit_cnt", 32'(cnt0), 32'd0);
        chk("clear_busy", 32'(busy0), 32'd0);
        chk("clear_pdata_held", 32'(pdata0), 32'h8001);
        chk("clear_frame_err_held", 32'(ferr0), 32'd1);
        sclrn = 1'b1;
        repeat (6) @(posedge clk);
        send_bits(32'hBEEF, 16);
        pulse_en(16'hBEEF, 16'hF77D, 1'b0, 0);

        // Async reset mid-frame
        send_bits(32'h7F, 7);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("midrst_pdata", 32'(pdata0), 32'd0);
        chk("midrst_bit_cnt", 32'(cnt0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_frame_err", 32'(ferr0), 32'd0);
        chk("midrst_valid", 32'(valid0), 32'd0);
        repeat (2) @(posedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        send_bits(32'h5A5A, 16);
        pulse_en(16'h5A5A, 16'h5A5A, 1'b0, 3);

        // Latch with nothing received, sclk toggled while en is high
        pulse_en(16'h0000, 16'h0000, 1'b1, 3);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_s2p_rx.md
Name: led_s2p_rx

Overview:
- Serial-to-parallel receiver: the far end of the board LED shift-register link (sclk / sdata / sclrn / latch-enable).
- Operates in the system clk domain. Oversamples the serial lines and rebuilds the DATA_BITS-wide word the transmitter shifted out. Presents the word with a one-cycle valid strobe on each latch.
- Used as an on-chip loopback checker for the LED serial driver and as a model of the external shift-register chain in simulation.

Parameters:
- DATA_BITS, 16, word width per frame.
- DATA_COUNT_BITS, 5, bit-counter width; must satisfy 2^DATA_COUNT_BITS > DATA_BITS.
- DIR, 0, bit order. 0: first received bit ends in PData[DATA_BITS-1] (MSB first, shift left). 1: first received bit ends in PData[0] (LSB first, shift right).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  serial shift clock from the transmitter; asynchronous to clk.
- sdin  input  1  serial data, valid around sclk rising edge.
- sclrn  input  1  active-low clear of the serial chain.
- en  input  1  latch strobe; a rising edge transfers the received word.
- PData  output  DATA_BITS  last latched word.
- valid  output  1  one-clk pulse when PData updates.
- frame_err  output  1  latched-frame bit count != DATA_BITS; holds until the next latch.
- busy  output  1  high while in RECV state.
- bit_cnt  output  DATA_COUNT_BITS  bits received in the current frame; saturates at DATA_BITS+1.

Behaviour:
- Synchronisation:
  - sclk, sdin, sclrn and en each pass through a 2-FF synchroniser, then one edge-detect register.
  - sdin is delayed identically to sclk, so the sampled bit is the value present at the sclk rising edge.
  - sclk/sdin must stay stable for at least 3 clk periods per level.
- Reset (rst=1, async): PData=0, valid=0, frame_err=0, busy=0, bit_cnt=0, shift register=0, synchronisers=0, state=IDLE.
- Event priority within one clk cycle: sclrn_s low > en rising edge > sclk rising edge.
- Clear: while sclrn_s=0, the shift register and bit_cnt are 0 and state=IDLE. Outputs PData and frame_err are untouched.
- FSM states:
  - IDLE: busy=0. An sclk rising edge shifts in sdin, sets bit_cnt=1 and moves to RECV.
  - RECV: busy=1. Each sclk rising edge shifts in one bit and increments bit_cnt, saturating at DATA_BITS+1. Once the count exceeds DATA_BITS, older bits fall off the far end.
  - LATCH: entered on an en_s rising edge from IDLE or RECV.
    - PData <= shift register; valid=1 for exactly one cycle.
    - frame_err <= (bit_cnt != DATA_BITS).
    - Then clears the shift register and bit_cnt and returns to IDLE.
- sclk edges while en_s=1 are ignored. They are neither shifted nor counted.
- en rising edge in IDLE with bit_cnt=0: latches 0 with frame_err=1 and valid=1.
- Latency: en rising at the pins → valid high on the 3rd clk rising edge after en is sampled high by the first synchroniser FF. PData is stable from that edge.
- Shift rule:
  - DIR=0: sr <= {sr[DATA_BITS-2:0], sdin_s}.
  - DIR=1: sr <= {sdin_s, sr[DATA_BITS-1:1]}.
- Reset mid-frame: all state is lost immediately. Subsequent bits start a new frame from bit_cnt=0.

Test Plan:
- DATA_BITS=16, DIR=0: shift 0xA5C3 MSB first with sclk period 20 clk, then pulse en → PData=0xA5C3, valid high exactly 1 cycle, frame_err=0, bit_cnt back to 0, busy=0.
- DIR=1: shift 0x0001 LSB first (bit0=1 first), then latch → PData=0x0001, frame_err=0.
- Short frame: shift 8 bits 0xFF, then pulse en → PData=0x00FF (DIR=0), frame_err=1. A following correct 16-bit frame 0x1234 → PData=0x1234, frame_err=0.
- Overflow: 17 bits, 1 followed by 0x8001 → bit_cnt=17, PData=0x8001, frame_err=1.
- sclrn low for 5 clk after 10 bits of 0x3FF, then 16 bits 0xBEEF, then latch → PData=0xBEEF, frame_err=0. PData unchanged during the clear.
- Async rst asserted mid-frame (after 7 bits) and released, then 16 bits 0x5A5A and latch → outputs 0 during reset, then PData=0x5A5A, frame_err=0. sclk edges while en high are not counted.
